// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: FSM state encoding,
// raw active-high segment patterns {g,f,e,d,c,b,a} and the hex decode table.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

    // All segments dark in raw (active-high) form.
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Maps a hex nibble to its raw segment pattern (lowercase b and d).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] pattern;
        case (hex)
            4'h0:    pattern = SEG_HEX_0;
            4'h1:    pattern = SEG_HEX_1;
            4'h2:    pattern = SEG_HEX_2;
            4'h3:    pattern = SEG_HEX_3;
            4'h4:    pattern = SEG_HEX_4;
            4'h5:    pattern = SEG_HEX_5;
            4'h6:    pattern = SEG_HEX_6;
            4'h7:    pattern = SEG_HEX_7;
            4'h8:    pattern = SEG_HEX_8;
            4'h9:    pattern = SEG_HEX_9;
            4'hA:    pattern = SEG_HEX_A;
            4'hB:    pattern = SEG_HEX_B;
            4'hC:    pattern = SEG_HEX_C;
            4'hD:    pattern = SEG_HEX_D;
            4'hE:    pattern = SEG_HEX_E;
            default: pattern = SEG_HEX_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purely combinational hex-to-seven-segment decoder producing raw
// active-high segments {g,f,e,d,c,b,a}.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; polarity handling lives in the scanner.
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Self-timed multiplexed driver for an N-digit seven-segment display.
// Each digit is lit for DIV clocks, followed by GUARD_CYCLES dark clocks to
// suppress ghosting. The digit value and blank bit are captured when a digit
// is entered so mid-interval input changes never tear the displayed value.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int DIV            = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [6:0]                    seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int PMAX = (DIV > GUARD_CYCLES) ? DIV : GUARD_CYCLES;
    localparam int PW   = $clog2(PMAX);

    localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? PW'(GUARD_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [3:0]            nib_q, nib_d;
    logic                  seg_on_q, seg_on_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [IW-1:0]         didx_q, didx_d;

    logic                  load;
    logic [IW-1:0]         load_idx;
    logic [IW-1:0]         next_idx;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_raw;

    // seg_on_q is the captured "not blanked and currently lit" flag; it gates
    // the decoder output so GUARD, IDLE and blanked digits stay dark.
    seven_seg_decoder u_decoder (
        .hex (nib_q),
        .seg (dec_seg)
    );

    // State register plus all datapath registers, cleared asynchronously so
    // the pins go dark the moment reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            presc_q  <= '0;
            nib_q    <= '0;
            seg_on_q <= 1'b0;
            sel_q    <= '0;
            didx_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            nib_q    <= nib_d;
            seg_on_q <= seg_on_d;
            sel_q    <= sel_d;
            didx_q   <= didx_d;
        end
    end

    // Next-state and next-output logic; entering SHOW is funnelled through
    // the load path so every entry captures the digit the same way.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        nib_d    = nib_q;
        seg_on_d = seg_on_q;
        sel_d    = sel_q;
        didx_d   = didx_q;
        load     = 1'b0;
        load_idx = idx_q;
        next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        if (!en) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            presc_d  = '0;
            sel_d    = '0;
            seg_on_d = 1'b0;
            didx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load     = 1'b1;
                    load_idx = '0;
                end
                ST_SHOW: begin
                    if (presc_q == DIV_LAST) begin
                        idx_d = next_idx;
                        if (GUARD_CYCLES > 0) begin
                            state_d  = ST_GUARD;
                            presc_d  = '0;
                            sel_d    = '0;
                            seg_on_d = 1'b0;
                        end else begin
                            load     = 1'b1;
                            load_idx = next_idx;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_GUARD: begin
                    if (presc_q == GUARD_LAST) begin
                        load     = 1'b1;
                        load_idx = idx_q;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    presc_d  = '0;
                    sel_d    = '0;
                    seg_on_d = 1'b0;
                    didx_d   = '0;
                end
            endcase
        end

        if (load) begin
            state_d         = ST_SHOW;
            idx_d           = load_idx;
            presc_d         = '0;
            nib_d           = digits[{load_idx, 2'b00} +: 4];
            seg_on_d        = ~blank_mask[load_idx];
            sel_d           = '0;
            sel_d[load_idx] = 1'b1;
            didx_d          = load_idx;
        end
    end

    // Blanking gate and pin polarity, applied after the registers.
    always_comb begin
        seg_raw   = seg_on_q ? dec_seg : SEG_OFF;
        seg       = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        digit_sel = (SEL_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
        digit_idx = didx_q;
    end

endmodule
